// File: rtl/ioblock_cfg_pkg.sv
// Shared types and constants for the I/O block serial configuration controller.
package ioblock_cfg_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StLoad,
    StCheck,
    StCommit
  } cfg_state_e;

  localparam logic [7:0] SyncDefault = 8'hA5;
  localparam int unsigned BitsPerPad = 3;

  // TSMUX encodings; 2'b11 behaves the same as TsmuxDrive.
  localparam logic [1:0] TsmuxZ     = 2'b00;
  localparam logic [1:0] TsmuxTs    = 2'b01;
  localparam logic [1:0] TsmuxDrive = 2'b10;

endpackage

// File: rtl/ioblock_cfg_ctrl_if.sv
// Serial configuration stream and committed pad-control bus.
interface ioblock_cfg_ctrl_if #(
  parameter int unsigned NPADS = 4
);
  logic                 CFG_EN;
  logic                 CFG_DIN;
  logic [2*NPADS-1:0]   TSMUX_O;
  logic [NPADS-1:0]     DORREG_O;
  logic                 CFG_BUSY;
  logic                 CFG_DONE;
  logic                 CFG_ERR;

  modport master (
    output CFG_EN, CFG_DIN,
    input  TSMUX_O, DORREG_O, CFG_BUSY, CFG_DONE, CFG_ERR
  );

  modport slave (
    input  CFG_EN, CFG_DIN,
    output TSMUX_O, DORREG_O, CFG_BUSY, CFG_DONE, CFG_ERR
  );
endinterface

// File: rtl/ioblock_cfg_shift.sv
// Shadow shift register for the configuration payload with a running even-parity accumulator.
module ioblock_cfg_shift #(
  parameter int unsigned Width = 12
) (
  input  logic             IOCLK,
  input  logic             RST,
  input  logic             clr_i,
  input  logic             shift_en_i,
  input  logic             din_i,
  output logic [Width-1:0] shadow_o,
  output logic             parity_o
);

  logic [Width-1:0] shadow_q;
  logic             parity_q;

  // First payload bit ends up in the MSB once the whole payload is loaded.
  always_ff @(posedge IOCLK) begin
    if (RST || clr_i) begin
      shadow_q <= '0;
      parity_q <= 1'b0;
    end else if (shift_en_i) begin
      shadow_q <= {shadow_q[Width-2:0], din_i};
      parity_q <= parity_q ^ din_i;
    end
  end

  assign shadow_o = shadow_q;
  assign parity_o = parity_q;

endmodule

// File: rtl/ioblock_cfg_ctrl.sv
// Serial configuration controller for a bank of I/O blocks: sync hunt, shadow load, atomic commit.
// Optional trailing even-parity check is enabled by defining PARITY_CHECK_EN.
module ioblock_cfg_ctrl
  import ioblock_cfg_pkg::*;
#(
  parameter int unsigned NPADS = 4,
  parameter logic [7:0]  SYNC  = SyncDefault
) (
  input  logic               IOCLK,
  input  logic               RST,
  ioblock_cfg_ctrl_if.slave  cfg
);

  localparam int unsigned PayloadBits = BitsPerPad * NPADS;
  localparam int unsigned CntW        = $clog2(PayloadBits + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(PayloadBits - 1);

  cfg_state_e             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [7:0]             win_q, win_d;
  logic [7:0]             win_shift;
  logic [2*NPADS-1:0]     tsmux_q, tsmux_new;
  logic [NPADS-1:0]       dorreg_q, dorreg_new;
  logic                   done_q;
  logic                   shift_en, shift_clr, commit;
  logic [PayloadBits-1:0] shadow;
  logic                   parity;
`ifdef PARITY_CHECK_EN
  logic                   err_q, err_set;
`else
  logic                   unused_parity;
  assign unused_parity = parity;
`endif

  ioblock_cfg_shift #(
    .Width (PayloadBits)
  ) u_shift (
    .IOCLK      (IOCLK),
    .RST        (RST),
    .clr_i      (shift_clr),
    .shift_en_i (shift_en),
    .din_i      (cfg.CFG_DIN),
    .shadow_o   (shadow),
    .parity_o   (parity)
  );

  // Pad 0 arrived first, so it occupies the top three shadow bits.
  for (genvar i = 0; i < NPADS; i++) begin : g_unpack
    assign tsmux_new[2*i +: 2] = shadow[PayloadBits-1-BitsPerPad*i -: 2];
    assign dorreg_new[i]       = shadow[PayloadBits-3-BitsPerPad*i];
  end

  assign win_shift = {win_q[6:0], cfg.CFG_DIN};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    shift_en  = 1'b0;
    shift_clr = 1'b0;
    commit    = 1'b0;
`ifdef PARITY_CHECK_EN
    err_set   = 1'b0;
`endif
    case (state_q)
      StHunt: begin
        if (cfg.CFG_EN) begin
          win_d = win_shift;
          if (win_shift == SYNC) begin
            state_d   = StLoad;
            cnt_d     = '0;
            shift_clr = 1'b1;
            win_d     = '0;
          end
        end
      end
      StLoad: begin
        if (cfg.CFG_EN) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
`ifdef PARITY_CHECK_EN
            state_d = StCheck;
`else
            state_d = StCommit;
`endif
          end
        end
      end
      StCheck: begin
`ifdef PARITY_CHECK_EN
        if (cfg.CFG_EN) begin
          if (cfg.CFG_DIN == parity) begin
            state_d = StCommit;
          end else begin
            err_set = 1'b1;
            state_d = StHunt;
          end
        end
`else
        state_d = StHunt;
`endif
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StHunt;
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge IOCLK) begin
    if (RST) begin
      state_q  <= StHunt;
      cnt_q    <= '0;
      win_q    <= '0;
      tsmux_q  <= '0;
      dorreg_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      done_q  <= commit;
      if (commit) begin
        tsmux_q  <= tsmux_new;
        dorreg_q <= dorreg_new;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge IOCLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end
  assign cfg.CFG_ERR = err_q;
`else
  assign cfg.CFG_ERR = 1'b0;
`endif

  assign cfg.TSMUX_O  = tsmux_q;
  assign cfg.DORREG_O = dorreg_q;
  assign cfg.CFG_BUSY = (state_q != StHunt);
  assign cfg.CFG_DONE = done_q;

endmodule

// File: tb/tb_ioblock_cfg_ctrl.sv
// Scoreboard bench for ioblock_cfg_ctrl with NPADS=2; adapts to PARITY_CHECK_EN.
module tb_ioblock_cfg_ctrl;

  typedef struct packed {
    logic [3:0] ts;
    logic [1:0] dr;
    logic       err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;
  exp_t exp_q[$];

  ioblock_cfg_ctrl_if #(.NPADS(2)) cfg ();

  ioblock_cfg_ctrl #(
    .NPADS (2),
    .SYNC  (8'hA5)
  ) dut (
    .IOCLK (clk),
    .RST   (rst),
    .cfg   (cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every CFG_DONE pulse must match the oldest expected commit.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && cfg.CFG_DONE === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("commit_tsmux", 32'(cfg.TSMUX_O), 32'(e.ts));
          chk("commit_dorreg", 32'(cfg.DORREG_O), 32'(e.dr));
          chk("commit_err", 32'(cfg.CFG_ERR), 32'(e.err));
        end
      end
    end
  end

  // Called at a negedge; returns at a negedge after the bit and any idle gap.
  task automatic send_bit(input logic b, input int gap, input bit chk_busy);
    cfg.CFG_EN  = 1'b1;
    cfg.CFG_DIN = b;
    @(negedge clk);
    cfg.CFG_EN  = 1'b0;
    cfg.CFG_DIN = 1'($urandom);
    for (int g = 0; g < gap; g++) begin
      if (chk_busy) chk("busy_during_stall", 32'(cfg.CFG_BUSY), 32'd1);
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] sy, input logic [5:0] pl, input logic par,
                            input int gap, input bit exp_commit);
    int gap_i;
    for (int i = 7; i >= 0; i--) send_bit(sy[i], 0, 1'b0);
    for (int i = 5; i >= 0; i--) begin
      gap_i = gap;
`ifndef PARITY_CHECK_EN
      if (i == 0) gap_i = 0;
`endif
      send_bit(pl[i], gap_i, exp_commit && (gap > 0));
    end
`ifdef PARITY_CHECK_EN
    send_bit(par, 0, 1'b0);
`else
    if (par === 1'bx) chk("par_known", 32'd0, 32'd1);
`endif
    if (exp_commit) begin
      chk("busy_in_commit", 32'(cfg.CFG_BUSY), 32'd1);
      chk("done_before_commit", 32'(cfg.CFG_DONE), 32'd0);
      @(negedge clk);
      chk("done_pulse", 32'(cfg.CFG_DONE), 32'd1);
      @(negedge clk);
      chk("done_single", 32'(cfg.CFG_DONE), 32'd0);
      chk("busy_after_commit", 32'(cfg.CFG_BUSY), 32'd0);
    end
  endtask

  localparam logic [5:0] Pl1 = 6'b011100;
  localparam logic [5:0] Pl2 = 6'b101111;
  localparam logic [5:0] Pl3 = 6'b000011;

  initial begin
    logic [4:0] prefix;
    n_run       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    cfg.CFG_EN  = 1'b1;
    cfg.CFG_DIN = 1'b0;

    // Reset with the strobe active and random data.
    repeat (2) begin
      @(negedge clk);
      cfg.CFG_DIN = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_tsmux", 32'(cfg.TSMUX_O), 32'd0);
    chk("rst_dorreg", 32'(cfg.DORREG_O), 32'd0);
    chk("rst_busy", 32'(cfg.CFG_BUSY), 32'd0);
    chk("rst_done", 32'(cfg.CFG_DONE), 32'd0);
    chk("rst_err", 32'(cfg.CFG_ERR), 32'd0);
    rst        = 1'b0;
    cfg.CFG_EN = 1'b0;
    @(negedge clk);

    // Good frame.
    exp_q.push_back('{ts: 4'b1001, dr: 2'b01, err: 1'b0});
    send_frame(8'hA5, Pl1, 1'b1, 0, 1'b1);

`ifdef PARITY_CHECK_EN
    // Bad parity: flagged, outputs untouched, no commit.
    send_frame(8'hA5, Pl1, 1'b0, 0, 1'b0);
    chk("perr_err", 32'(cfg.CFG_ERR), 32'd1);
    chk("perr_busy", 32'(cfg.CFG_BUSY), 32'd0);
    repeat (3) @(negedge clk);
    chk("perr_tsmux_hold", 32'(cfg.TSMUX_O), 32'b1001);
    chk("perr_dorreg_hold", 32'(cfg.DORREG_O), 32'b01);
    chk("perr_err_sticky", 32'(cfg.CFG_ERR), 32'd1);
`endif

    // Next good frame clears the error.
    exp_q.push_back('{ts: 4'b1110, dr: 2'b11, err: 1'b0});
    send_frame(8'hA5, Pl2, 1'b1, 0, 1'b1);

    // Sync hunt behind a misleading prefix.
    prefix = 5'b11010;
    for (int i = 4; i >= 0; i--) send_bit(prefix[i], 0, 1'b0);
    chk("hunt_prefix_busy", 32'(cfg.CFG_BUSY), 32'd0);
    exp_q.push_back('{ts: 4'b1001, dr: 2'b01, err: 1'b0});
    send_frame(8'hA5, Pl1, 1'b1, 0, 1'b1);

    // Wrong sync word: never leaves HUNT.
    send_frame(8'hA4, Pl2, 1'b1, 0, 1'b0);
    repeat (4) @(negedge clk);
    chk("badsync_busy", 32'(cfg.CFG_BUSY), 32'd0);
    chk("badsync_tsmux", 32'(cfg.TSMUX_O), 32'b1001);
    chk("badsync_dorreg", 32'(cfg.DORREG_O), 32'b01);

    // Good frame with 5-cycle gaps after every payload bit.
    exp_q.push_back('{ts: 4'b1110, dr: 2'b11, err: 1'b0});
    send_frame(8'hA5, Pl2, 1'b1, 5, 1'b1);

    // Reset three bits into the payload.
    for (int i = 7; i >= 0; i--) send_bit(1'(8'hA5 >> i), 0, 1'b0);
    for (int i = 5; i >= 3; i--) send_bit(Pl1[i], 0, 1'b0);
    chk("midrst_busy_before", 32'(cfg.CFG_BUSY), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_tsmux", 32'(cfg.TSMUX_O), 32'd0);
    chk("midrst_dorreg", 32'(cfg.DORREG_O), 32'd0);
    chk("midrst_busy", 32'(cfg.CFG_BUSY), 32'd0);
    chk("midrst_done", 32'(cfg.CFG_DONE), 32'd0);
    exp_q.push_back('{ts: 4'b0100, dr: 2'b10, err: 1'b0});
    send_frame(8'hA5, Pl3, 1'b0, 0, 1'b1);

    repeat (4) @(negedge clk);
    chk("all_commits_seen", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
